// File: rtl/acs_pm_unit.sv
// Registered add-compare-select with path-metric storage for a rate-1/n Viterbi decoder.
// Handles 2^(K-1) states, frame-start init, MSB-clear renormalisation, saturation and valid/ready.
module acs_pm_unit #(
  parameter int K       = 3,
  parameter int BM_W    = 2,
  parameter int PM_W    = 8,
  parameter int INIT_PM = 64
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              valid_i,
  output logic                              ready_o,
  input  logic                              start_i,
  input  logic [2*(1<<(K-1))*BM_W-1:0]      bm_i,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [(1<<(K-1))-1:0]             dec_bits_o,
  output logic [(1<<(K-1))*PM_W-1:0]        pm_o,
  output logic [K-2:0]                      best_state_o,
  output logic                              norm_o
);

  localparam int N    = 1 << (K - 1);
  localparam int M    = K - 1;
  localparam int HALF = N / 2;

  logic                  w_accept;
  logic                  w_all_msb;
  logic                  w_norm;
  logic [N-1:0]          w_msb;
  logic [N-1:0]          w_dec;
  logic [N*PM_W-1:0]     w_src_all;
  logic [N*PM_W-1:0]     w_new_all;
  logic [(N-1)*PM_W-1:0] w_min_chain;
  logic [N*M-1:0]        w_idx_chain;
  logic [M-1:0]          w_best;

  logic                  r_valid;
  logic [N-1:0]          r_dec;
  logic [M-1:0]          r_best;
  logic                  r_norm;

  assign ready_o   = !r_valid || ready_i;
  assign w_accept  = valid_i && ready_o;
  // Renormalise only registered metrics; start values bypass the check.
  assign w_all_msb = &w_msb;
  assign w_norm    = !start_i && w_all_msb;
  assign w_best    = w_idx_chain[(N-1)*M +: M];

  for (genvar j = 0; j < N; j++) begin : gen_state
    localparam int              P0     = (j % HALF) * 2;
    localparam logic [PM_W-1:0] RST_PM = (j == 0) ? '0 : PM_W'(INIT_PM);
    localparam logic [M-1:0]    J_IDX  = M'(j);

    logic [PM_W-1:0] r_pm;
    logic [PM_W-1:0] w_src;
    logic [PM_W:0]   w_sum0;
    logic [PM_W:0]   w_sum1;
    logic [PM_W-1:0] w_c0;
    logic [PM_W-1:0] w_c1;
    logic            w_pick1;
    logic [PM_W-1:0] w_new;

    assign w_msb[j] = r_pm[PM_W-1];

    always_comb begin
      w_src = r_pm;
      if (start_i) begin
        w_src = RST_PM;
      end else if (w_all_msb) begin
        w_src = {1'b0, r_pm[PM_W-2:0]};
      end
    end

    assign w_src_all[j*PM_W +: PM_W] = w_src;

    assign w_sum0 = {1'b0, w_src_all[P0*PM_W +: PM_W]}
                  + {{(PM_W+1-BM_W){1'b0}}, bm_i[(2*j)*BM_W +: BM_W]};
    assign w_sum1 = {1'b0, w_src_all[(P0+1)*PM_W +: PM_W]}
                  + {{(PM_W+1-BM_W){1'b0}}, bm_i[(2*j+1)*BM_W +: BM_W]};

    assign w_c0    = w_sum0[PM_W] ? '1 : w_sum0[PM_W-1:0];
    assign w_c1    = w_sum1[PM_W] ? '1 : w_sum1[PM_W-1:0];
    // Strict compare: a tie keeps candidate 0.
    assign w_pick1 = w_c1 < w_c0;
    assign w_new   = w_pick1 ? w_c1 : w_c0;

    assign w_dec[j]                  = w_pick1;
    assign w_new_all[j*PM_W +: PM_W] = w_new;
    assign pm_o[j*PM_W +: PM_W]      = r_pm;

    // Running minimum; strict compare keeps the lowest index on ties.
    if (j == 0) begin : gen_best_first
      assign w_min_chain[0 +: PM_W] = w_new;
      assign w_idx_chain[0 +: M]    = '0;
    end else begin : gen_best_next
      logic w_take;
      assign w_take = w_new < w_min_chain[(j-1)*PM_W +: PM_W];
      assign w_idx_chain[j*M +: M] = w_take ? J_IDX : w_idx_chain[(j-1)*M +: M];
      if (j < N - 1) begin : gen_min_fwd
        assign w_min_chain[j*PM_W +: PM_W] = w_take ? w_new
                                                    : w_min_chain[(j-1)*PM_W +: PM_W];
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_pm <= RST_PM;
      end else if (w_accept) begin
        r_pm <= w_new;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_dec   <= '0;
      r_best  <= '0;
      r_norm  <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_dec   <= w_dec;
      r_best  <= w_best;
      r_norm  <= w_norm;
    end else if (ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign valid_o      = r_valid;
  assign dec_bits_o   = r_dec;
  assign best_state_o = r_best;
  assign norm_o       = r_norm;

endmodule

// File: tb/tb_acs_pm_unit.sv
// Bench for acs_pm_unit (K=3): directed trellis cases plus randomized steps against an arithmetic reference.
module tb_acs_pm_unit;

  localparam int INIT = 64;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i;
  logic        valid_i;
  logic        start_i;
  logic        ready_i;
  logic [15:0] bm_i;

  logic        a_ready, a_valid, a_norm;
  logic [3:0]  a_dec;
  logic [31:0] a_pm;
  logic [1:0]  a_best;

  logic        b_ready, b_valid, b_norm;
  logic [3:0]  b_dec;
  logic [31:0] b_pm;
  logic [1:0]  b_best;

  acs_pm_unit #(.K(3), .BM_W(2), .PM_W(8), .INIT_PM(INIT)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(a_ready),
    .start_i(start_i), .bm_i(bm_i), .valid_o(a_valid), .ready_i(ready_i),
    .dec_bits_o(a_dec), .pm_o(a_pm), .best_state_o(a_best), .norm_o(a_norm)
  );

  acs_pm_unit #(.K(3), .BM_W(2), .PM_W(8), .INIT_PM(254)) u_dut_sat (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(b_ready),
    .start_i(start_i), .bm_i(bm_i), .valid_o(b_valid), .ready_i(ready_i),
    .dec_bits_o(b_dec), .pm_o(b_pm), .best_state_o(b_best), .norm_o(b_norm)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: metrics as plain integers, output register as expected values.
  int         ref_pm[4];
  logic       exp_valid;
  logic [3:0] exp_dec;
  logic [1:0] exp_best;
  logic       exp_norm;

  function automatic void ref_reset();
    ref_pm[0] = 0;
    for (int j = 1; j < 4; j++) ref_pm[j] = INIT;
    exp_valid = 1'b0;
    exp_dec   = '0;
    exp_best  = '0;
    exp_norm  = 1'b0;
  endfunction

  function automatic void ref_step(input logic s, input logic [15:0] b);
    int src[4];
    bit hi;
    int c0, c1, p;
    hi = 1'b1;
    for (int j = 0; j < 4; j++) if (ref_pm[j] < 128) hi = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (s) src[j] = (j == 0) ? 0 : INIT;
      else   src[j] = hi ? ref_pm[j] - 128 : ref_pm[j];
    end
    exp_norm = !s && hi;
    for (int j = 0; j < 4; j++) begin
      p  = 2 * (j % 2);
      c0 = src[p]     + int'(b[4*j +: 2]);
      c1 = src[p + 1] + int'(b[4*j + 2 +: 2]);
      if (c0 > 255) c0 = 255;
      if (c1 > 255) c1 = 255;
      exp_dec[j] = (c1 < c0);
      ref_pm[j]  = (c1 < c0) ? c1 : c0;
    end
    exp_best = 2'd0;
    for (int j = 1; j < 4; j++) if (ref_pm[j] < ref_pm[exp_best]) exp_best = 2'(j);
    exp_valid = 1'b1;
  endfunction

  function automatic logic [31:0] ref_pm_packed();
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[j*8 +: 8] = ref_pm[j][7:0];
    return r;
  endfunction

  task automatic check_outputs(input string pfx);
    check({pfx, ".valid"}, a_valid, exp_valid);
    check({pfx, ".pm"},    a_pm,    ref_pm_packed());
    check({pfx, ".dec"},   a_dec,   exp_dec);
    check({pfx, ".best"},  a_best,  exp_best);
    check({pfx, ".norm"},  a_norm,  exp_norm);
  endtask

  task automatic cyc(input string pfx, input logic v, input logic s,
                     input logic [15:0] b, input logic r);
    logic acc;
    valid_i = v;
    start_i = s;
    bm_i    = b;
    ready_i = r;
    #1;
    check({pfx, ".ready"}, a_ready, !exp_valid || r);
    acc = v && (!exp_valid || r);
    @(posedge clk);
    if (acc) ref_step(s, b);
    else if (r) exp_valid = 1'b0;
    #1;
    check_outputs(pfx);
  endtask

  task automatic do_reset(input string pfx);
    rst_i   = 1'b1;
    valid_i = 1'b1;
    start_i = 1'b0;
    bm_i    = 16'($urandom);
    ready_i = 1'b0;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    ref_reset();
    check_outputs(pfx);
    check({pfx, ".ready"}, a_ready, 1'b1);
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; start_i = 1'b0; ready_i = 1'b0; bm_i = '0;
    ref_reset();
    do_reset("init");

    // Saturation on the INIT_PM=254 instance: {0,254,254,254} with bm2=bm3=3.
    cyc("sat", 1'b1, 1'b1, 16'h00F0, 1'b1);
    check("sat.pm1",   b_pm[15:8], 32'd255);
    check("sat.pm",    b_pm,       32'hFE00_FF00);
    check("sat.dec",   b_dec,      4'b0000);
    check("sat.norm",  b_norm,     1'b0);
    check("sat.valid", b_valid,    1'b1);
    check("sat.best",  b_best,     2'd0);
    check("sat.ready", b_ready,    1'b1);

    // Stall with a pending result, then reset mid-stall.
    cyc("stall", 1'b1, 1'b0, 16'h1234, 1'b0);
    do_reset("rst_stall");
    check("rst_stall.pm_const", a_pm, 32'h4040_4000);

    // First step of a frame; state 1 ties 65/65.
    cyc("start", 1'b1, 1'b1, 16'h5554, 1'b1);
    check("start.pm_const",  a_pm,  32'h4101_4100);
    check("start.dec_const", a_dec, 4'b0000);

    // All-3 metrics: every state reaches 129 after step 43, renormalises on 44.
    cyc("ren1", 1'b1, 1'b1, 16'hFFFF, 1'b1);
    for (int n = 2; n <= 43; n++) cyc("ren", 1'b1, 1'b0, 16'hFFFF, 1'b1);
    check("ren43.pm_const", a_pm, 32'h8181_8181);
    check("ren43.norm_const", a_norm, 1'b0);
    cyc("ren44", 1'b1, 1'b0, 16'hFFFF, 1'b1);
    check("ren44.norm_const", a_norm, 1'b1);
    check("ren44.pm0_const",  a_pm[7:0], 32'd4);
    cyc("ren45", 1'b1, 1'b0, 16'hFFFF, 1'b1);
    check("ren45.norm_const", a_norm, 1'b0);
    check("ren45.pm_const",   a_pm, 32'h0707_0707);

    // State 0 picks candidate 1 (10 vs 7); other states tie and keep candidate 0.
    cyc("dec1", 1'b1, 1'b0, 16'h0003, 1'b1);
    check("dec1.dec_const", a_dec, 4'b0001);
    check("dec1.pm0_const", a_pm[7:0], 32'd7);

    // Backpressure: five stalled cycles with changing bm, then release.
    for (int n = 0; n < 5; n++) cyc("bp", 1'b1, 1'b0, 16'($urandom), 1'b0);
    cyc("bp_rel", 1'b1, 1'b0, 16'($urandom), 1'b1);
    cyc("bp_drain", 1'b0, 1'b0, 16'($urandom), 1'b1);

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset("rnd_rst");
      end else begin
        cyc("rnd", $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
            16'($urandom), $urandom_range(0, 3) != 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
